// File: rtl/usb_txn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : usb_txn_ctrl
//  Description : USB host-side transaction sequencer. Accepts one OUT or IN
//                transaction request, drives the packet encoder through
//                token / data / handshake packets, watches the packet decoder
//                for the device response, and retries failed attempts up to
//                MAX_ATTEMPTS times before reporting completion.
//  Ports       : clock, reset          - single clock, sync active-high reset
//                txn_*                 - transaction request / result side
//                tx_req/tx_pid/tx_addr/tx_endp/tx_data, tx_done
//                                      - packet encoder handshake
//                rx_valid/rx_pid/rx_data/rx_crc_ok
//                                      - packet decoder strobe and contents
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_txn_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_ATTEMPTS   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        txn_start,
    input  logic        txn_type,
    input  logic [6:0]  txn_addr,
    input  logic [3:0]  txn_endp,
    input  logic [63:0] txn_wdata,
    output logic        txn_ready,
    output logic        txn_done,
    output logic        txn_success,
    output logic [63:0] txn_rdata,
    output logic        tx_req,
    output logic [3:0]  tx_pid,
    output logic [6:0]  tx_addr,
    output logic [3:0]  tx_endp,
    output logic [63:0] tx_data,
    input  logic        tx_done,
    input  logic        rx_valid,
    input  logic [3:0]  rx_pid,
    input  logic [63:0] rx_data,
    input  logic        rx_crc_ok
);

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(MAX_ATTEMPTS + 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SEND_TOKEN = 3'd1,
        S_SEND_DATA  = 3'd2,
        S_WAIT_HS    = 3'd3,
        S_WAIT_DATA  = 3'd4,
        S_SEND_HS    = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          lat_type;
    logic [6:0]    lat_addr;
    logic [3:0]    lat_endp;
    logic [63:0]   lat_wdata;
    logic [AW-1:0] attempts;
    logic [TW-1:0] tmo;

    logic          fail;
    logic          capture;
    logic          done_ok;
    logic [3:0]    hs_pid;
    logic          tmo_hit;
    logic          last_attempt;
    // Token fields come straight from the request on the accepting edge,
    // because the latches are loaded on that same edge.
    logic          cur_type;
    logic [6:0]    cur_addr;
    logic [3:0]    cur_endp;

    assign tmo_hit      = (tmo == TW'(TIMEOUT_CYCLES - 1));
    assign last_attempt = ((attempts + AW'(1)) == AW'(MAX_ATTEMPTS));
    assign cur_type     = (state == S_IDLE) ? txn_type : lat_type;
    assign cur_addr     = (state == S_IDLE) ? txn_addr : lat_addr;
    assign cur_endp     = (state == S_IDLE) ? txn_endp : lat_endp;

    always_comb begin
        state_nxt = state;
        fail      = 1'b0;
        capture   = 1'b0;
        done_ok   = 1'b0;
        hs_pid    = PID_ACK;
        case (state)
            S_IDLE: begin
                if (txn_start) state_nxt = S_SEND_TOKEN;
            end
            S_SEND_TOKEN: begin
                if (tx_done) state_nxt = lat_type ? S_WAIT_DATA : S_SEND_DATA;
            end
            S_SEND_DATA: begin
                if (tx_done) state_nxt = S_WAIT_HS;
            end
            S_WAIT_HS: begin
                // A response in the final timeout cycle still wins.
                if (rx_valid) begin
                    if (rx_pid == PID_ACK) begin
                        state_nxt = S_DONE;
                        done_ok   = 1'b1;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (tmo_hit) begin
                    fail = 1'b1;
                end
            end
            S_WAIT_DATA: begin
                if (rx_valid) begin
                    if (rx_pid == PID_DATA0) begin
                        state_nxt = S_SEND_HS;
                        if (rx_crc_ok) capture = 1'b1;
                        else           hs_pid  = PID_NAK;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (tmo_hit) begin
                    fail = 1'b1;
                end
            end
            S_SEND_HS: begin
                // The handshake being sent is remembered in tx_pid itself.
                if (tx_done) begin
                    if (tx_pid == PID_ACK) begin
                        state_nxt = S_DONE;
                        done_ok   = 1'b1;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (fail) state_nxt = last_attempt ? S_DONE : S_SEND_TOKEN;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            txn_ready   <= 1'b1;
            txn_done    <= 1'b0;
            txn_success <= 1'b0;
            txn_rdata   <= '0;
            tx_req      <= 1'b0;
            tx_pid      <= '0;
            tx_addr     <= '0;
            tx_endp     <= '0;
            tx_data     <= '0;
            lat_type    <= 1'b0;
            lat_addr    <= '0;
            lat_endp    <= '0;
            lat_wdata   <= '0;
            attempts    <= '0;
            tmo         <= '0;
        end else begin
            state     <= state_nxt;
            txn_ready <= (state_nxt == S_IDLE);
            txn_done  <= (state_nxt == S_DONE);

            if (state == S_IDLE && txn_start) begin
                lat_type    <= txn_type;
                lat_addr    <= txn_addr;
                lat_endp    <= txn_endp;
                lat_wdata   <= txn_wdata;
                attempts    <= '0;
                txn_success <= 1'b0;
                txn_rdata   <= '0;
            end
            if (capture) txn_rdata <= rx_data;
            if (state_nxt == S_DONE) txn_success <= done_ok;
            if (fail) attempts <= attempts + AW'(1);

            if ((state_nxt == S_WAIT_HS || state_nxt == S_WAIT_DATA) && state_nxt != state)
                tmo <= '0;
            else if (state == S_WAIT_HS || state == S_WAIT_DATA)
                tmo <= tmo + TW'(1);

            // Encoder fields are loaded only on entry to a send state so they
            // stay frozen until the encoder reports completion.
            if (state_nxt != state) begin
                case (state_nxt)
                    S_SEND_TOKEN: begin
                        tx_req  <= 1'b1;
                        tx_pid  <= cur_type ? PID_IN : PID_OUT;
                        tx_addr <= cur_addr;
                        tx_endp <= cur_endp;
                        tx_data <= '0;
                    end
                    S_SEND_DATA: begin
                        tx_req  <= 1'b1;
                        tx_pid  <= PID_DATA0;
                        tx_addr <= lat_addr;
                        tx_endp <= lat_endp;
                        tx_data <= lat_wdata;
                    end
                    S_SEND_HS: begin
                        tx_req  <= 1'b1;
                        tx_pid  <= hs_pid;
                        tx_addr <= lat_addr;
                        tx_endp <= lat_endp;
                        tx_data <= '0;
                    end
                    default: tx_req <= 1'b0;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_txn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_txn_ctrl
//  Description : Directed scoreboard bench for usb_txn_ctrl. Expected encoder
//                packets and transaction results are queued as stimulus is
//                issued and compared as the design produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_txn_ctrl;

    localparam int TMO  = 16;
    localparam int MAXA = 8;

    localparam logic [3:0] P_OUT   = 4'b0001;
    localparam logic [3:0] P_IN    = 4'b1001;
    localparam logic [3:0] P_DATA0 = 4'b0011;
    localparam logic [3:0] P_ACK   = 4'b0010;
    localparam logic [3:0] P_NAK   = 4'b1010;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        txn_start = 1'b0;
    logic        txn_type = 1'b0;
    logic [6:0]  txn_addr = '0;
    logic [3:0]  txn_endp = '0;
    logic [63:0] txn_wdata = '0;
    logic        txn_ready, txn_done, txn_success;
    logic [63:0] txn_rdata;
    logic        tx_req;
    logic [3:0]  tx_pid;
    logic [6:0]  tx_addr;
    logic [3:0]  tx_endp;
    logic [63:0] tx_data;
    logic        tx_done = 1'b0;
    logic        rx_valid = 1'b0;
    logic [3:0]  rx_pid = '0;
    logic [63:0] rx_data = '0;
    logic        rx_crc_ok = 1'b0;

    always #5 clock = ~clock;

    usb_txn_ctrl #(.TIMEOUT_CYCLES(TMO), .MAX_ATTEMPTS(MAXA)) dut (
        .clock(clock), .reset(reset),
        .txn_start(txn_start), .txn_type(txn_type), .txn_addr(txn_addr),
        .txn_endp(txn_endp), .txn_wdata(txn_wdata),
        .txn_ready(txn_ready), .txn_done(txn_done), .txn_success(txn_success),
        .txn_rdata(txn_rdata),
        .tx_req(tx_req), .tx_pid(tx_pid), .tx_addr(tx_addr), .tx_endp(tx_endp),
        .tx_data(tx_data), .tx_done(tx_done),
        .rx_valid(rx_valid), .rx_pid(rx_pid), .rx_data(rx_data), .rx_crc_ok(rx_crc_ok)
    );

    typedef struct {
        logic [3:0]  pid;
        logic [6:0]  addr;
        logic [3:0]  endp;
        logic [63:0] data;
        bit          chk_ae;
        bit          chk_data;
    } pkt_t;

    typedef struct {
        logic        succ;
        logic [63:0] rdata;
        bit          chk_rdata;
    } res_t;

    pkt_t txq[$];
    res_t resq[$];
    int   checks = 0;
    int   passed = 0;
    int   failed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_tx(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                           input logic [63:0] data, input bit chk_ae, input bit chk_data);
        pkt_t p;
        p.pid = pid; p.addr = addr; p.endp = endp; p.data = data;
        p.chk_ae = chk_ae; p.chk_data = chk_data;
        txq.push_back(p);
    endtask

    // Called on a negedge; returns on a negedge.
    task automatic start_txn(input logic typ, input logic [6:0] addr, input logic [3:0] endp,
                             input logic [63:0] wdata, input logic succ,
                             input logic [63:0] rdata, input bit chk_rdata);
        res_t r;
        r.succ = succ; r.rdata = rdata; r.chk_rdata = chk_rdata;
        resq.push_back(r);
        txn_type = typ; txn_addr = addr; txn_endp = endp; txn_wdata = wdata;
        txn_start = 1'b1;
        @(negedge clock);
        txn_start = 1'b0;
    endtask

    // Waits for the next encoder request, compares it against the scoreboard,
    // confirms it is held for an extra cycle, then acknowledges it.
    // gap = number of sampled cycles with tx_req low before the request.
    task automatic tx_packet(output int gap);
        pkt_t e;
        gap = 0;
        while (tx_req !== 1'b1 && gap < 200) begin
            gap++;
            @(negedge clock);
        end
        if (tx_req !== 1'b1) begin
            check("tx_req_timeout", 64'(tx_req), 64'd1);
            return;
        end
        if (txq.size() == 0) begin
            check("tx_unexpected_packet", 64'(txq.size()), 64'd1);
            return;
        end
        e = txq.pop_front();
        check("tx_pid", 64'(tx_pid), 64'(e.pid));
        if (e.chk_ae) begin
            check("tx_addr", 64'(tx_addr), 64'(e.addr));
            check("tx_endp", 64'(tx_endp), 64'(e.endp));
        end
        if (e.chk_data) check("tx_data", tx_data, e.data);
        @(negedge clock);
        check("tx_hold_req", 64'(tx_req), 64'd1);
        check("tx_hold_pid", 64'(tx_pid), 64'(e.pid));
        tx_done = 1'b1;
        @(negedge clock);
        tx_done = 1'b0;
    endtask

    task automatic rx_send(input logic [3:0] pid, input logic [63:0] data, input logic crc);
        rx_valid = 1'b1; rx_pid = pid; rx_data = data; rx_crc_ok = crc;
        @(negedge clock);
        rx_valid = 1'b0; rx_pid = '0; rx_data = '0; rx_crc_ok = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        res_t r;
        bit   tx_seen;
        tx_seen = 1'b0;
        cyc = 0;
        while (txn_done !== 1'b1 && cyc < 400) begin
            if (tx_req === 1'b1) tx_seen = 1'b1;
            cyc++;
            @(negedge clock);
        end
        check("txn_done_seen", 64'(txn_done), 64'd1);
        check("no_tx_before_done", 64'(tx_seen), 64'd0);
        if (resq.size() == 0) begin
            check("result_queue_size", 64'(resq.size()), 64'd1);
            return;
        end
        r = resq.pop_front();
        check("txn_success", 64'(txn_success), 64'(r.succ));
        if (r.chk_rdata) check("txn_rdata", txn_rdata, r.rdata);
        @(negedge clock);
        check("txn_done_one_cycle", 64'(txn_done), 64'd0);
        check("txn_ready_after_done", 64'(txn_ready), 64'd1);
        check("txn_success_hold", 64'(txn_success), 64'(r.succ));
        if (r.chk_rdata) check("txn_rdata_hold", txn_rdata, r.rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        int cyc;
        bit seen;
        logic [63:0] w_out = 64'hDEADBEEF_01234567;
        logic [63:0] d_in  = 64'h0123456789ABCDEF;
        logic [63:0] d_in2 = 64'hCAFEF00D_5A5AA5A5;

        // ---- reset state ----
        repeat (3) @(negedge clock);
        check("rst_txn_ready", 64'(txn_ready), 64'd1);
        check("rst_txn_done", 64'(txn_done), 64'd0);
        check("rst_txn_success", 64'(txn_success), 64'd0);
        check("rst_txn_rdata", txn_rdata, 64'd0);
        check("rst_tx_req", 64'(tx_req), 64'd0);
        check("rst_tx_pid", 64'(tx_pid), 64'd0);
        check("rst_tx_addr", 64'(tx_addr), 64'd0);
        check("rst_tx_endp", 64'(tx_endp), 64'd0);
        check("rst_tx_data", tx_data, 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // ---- OUT transaction, device ACKs ----
        start_txn(1'b0, 7'd5, 4'd4, w_out, 1'b1, 64'd0, 1'b0);
        check("busy_not_ready", 64'(txn_ready), 64'd0);
        push_tx(P_OUT, 7'd5, 4'd4, 64'd0, 1'b1, 1'b0);
        push_tx(P_DATA0, 7'd5, 4'd4, w_out, 1'b1, 1'b1);
        tx_packet(g);
        check("out_token_latency", 64'(g), 64'd0);
        tx_packet(g);
        check("data_follows_token", 64'(g), 64'd0);
        check("wait_hs_no_req", 64'(tx_req), 64'd0);
        repeat (2) @(negedge clock);
        rx_send(P_ACK, 64'd0, 1'b1);
        wait_done(cyc);
        check("out_done_after_ack", 64'(cyc), 64'd0);

        // ---- IN transaction, good DATA0 ----
        start_txn(1'b1, 7'd5, 4'd4, 64'd0, 1'b1, d_in, 1'b1);
        push_tx(P_IN, 7'd5, 4'd4, 64'd0, 1'b1, 1'b0);
        tx_packet(g);
        repeat (3) @(negedge clock);
        rx_send(P_DATA0, d_in, 1'b1);
        push_tx(P_ACK, 7'd0, 4'd0, 64'd0, 1'b0, 1'b0);
        tx_packet(g);
        wait_done(cyc);

        // ---- OUT, NAK twice then ACK: exactly three tokens ----
        start_txn(1'b0, 7'h12, 4'h3, 64'h1111_2222_3333_4444, 1'b1, 64'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            push_tx(P_OUT, 7'h12, 4'h3, 64'd0, 1'b1, 1'b0);
            push_tx(P_DATA0, 7'h12, 4'h3, 64'h1111_2222_3333_4444, 1'b1, 1'b1);
            tx_packet(g);
            tx_packet(g);
            @(negedge clock);
            rx_send((i < 2) ? P_NAK : P_ACK, 64'd0, 1'b1);
        end
        wait_done(cyc);

        // ---- IN, no response: all attempts time out ----
        start_txn(1'b1, 7'd5, 4'd4, 64'd0, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < MAXA; i++) begin
            push_tx(P_IN, 7'd5, 4'd4, 64'd0, 1'b1, 1'b0);
            tx_packet(g);
            if (i > 0) check("timeout_gap", 64'(g), 64'(TMO));
        end
        wait_done(cyc);
        check("final_timeout_gap", 64'(cyc), 64'(TMO));

        // ---- IN, bad CRC -> NAK and retry, then good data ----
        start_txn(1'b1, 7'd5, 4'd4, 64'd0, 1'b1, d_in2, 1'b1);
        push_tx(P_IN, 7'd5, 4'd4, 64'd0, 1'b1, 1'b0);
        tx_packet(g);
        @(negedge clock);
        rx_send(P_DATA0, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0);
        push_tx(P_NAK, 7'd0, 4'd0, 64'd0, 1'b0, 1'b0);
        tx_packet(g);
        push_tx(P_IN, 7'd5, 4'd4, 64'd0, 1'b1, 1'b0);
        tx_packet(g);
        check("retry_after_nak", 64'(g), 64'd0);
        rx_send(P_DATA0, d_in2, 1'b1);
        push_tx(P_ACK, 7'd0, 4'd0, 64'd0, 1'b0, 1'b0);
        tx_packet(g);
        wait_done(cyc);

        // ---- response in the last timeout cycle beats the timeout ----
        start_txn(1'b1, 7'd9, 4'd1, 64'd0, 1'b1, d_in, 1'b1);
        push_tx(P_IN, 7'd9, 4'd1, 64'd0, 1'b1, 1'b0);
        tx_packet(g);
        repeat (TMO - 1) @(negedge clock);
        rx_send(P_DATA0, d_in, 1'b1);
        push_tx(P_ACK, 7'd0, 4'd0, 64'd0, 1'b0, 1'b0);
        tx_packet(g);
        wait_done(cyc);

        // ---- one cycle later is too late: timeout, stray rx ignored ----
        start_txn(1'b1, 7'd9, 4'd1, 64'd0, 1'b1, d_in2, 1'b1);
        push_tx(P_IN, 7'd9, 4'd1, 64'd0, 1'b1, 1'b0);
        tx_packet(g);
        repeat (TMO) @(negedge clock);
        check("retoken_after_timeout", 64'(tx_req), 64'd1);
        rx_send(P_DATA0, d_in, 1'b1);
        push_tx(P_IN, 7'd9, 4'd1, 64'd0, 1'b1, 1'b0);
        tx_packet(g);
        rx_send(P_DATA0, d_in2, 1'b1);
        push_tx(P_ACK, 7'd0, 4'd0, 64'd0, 1'b0, 1'b0);
        tx_packet(g);
        wait_done(cyc);

        // ---- reset during SEND_DATA aborts without txn_done ----
        start_txn(1'b0, 7'd5, 4'd4, w_out, 1'b1, 64'd0, 1'b0);
        push_tx(P_OUT, 7'd5, 4'd4, 64'd0, 1'b1, 1'b0);
        tx_packet(g);
        check("abort_in_send_data_req", 64'(tx_req), 64'd1);
        check("abort_in_send_data_pid", 64'(tx_pid), 64'(P_DATA0));
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_tx_req", 64'(tx_req), 64'd0);
        check("abort_txn_ready", 64'(txn_ready), 64'd1);
        check("abort_txn_done", 64'(txn_done), 64'd0);
        void'(resq.pop_front());
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (txn_done === 1'b1) seen = 1'b1;
            @(negedge clock);
        end
        check("abort_no_done", 64'(seen), 64'd0);

        // ---- fresh transaction after abort ----
        start_txn(1'b0, 7'd5, 4'd4, w_out, 1'b1, 64'd0, 1'b0);
        push_tx(P_OUT, 7'd5, 4'd4, 64'd0, 1'b1, 1'b0);
        push_tx(P_DATA0, 7'd5, 4'd4, w_out, 1'b1, 1'b1);
        tx_packet(g);
        tx_packet(g);
        rx_send(P_ACK, 64'd0, 1'b1);
        wait_done(cyc);

        check("txq_drained", 64'(txq.size()), 64'd0);
        check("resq_drained", 64'(resq.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
